// File: rtl/exc_pkg.sv
// Shared types and constants for the exception entry sequencer.
// Optional build macro: EXC_COUNT_EN (adds the accepted-exception counter).
package exc_pkg;

    // Sequencer states; encoding is exposed on the debug state port.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        FETCH   = 3'd2,
        WAIT    = 3'd3,
        LOAD_PC = 3'd4
    } state_e;

    // Exception cause codes, ordered so that code-1 indexes the vector table.
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_OPC  = 2'd1,
        CAUSE_OVF  = 2'd2,
        CAUSE_DIV0 = 2'd3
    } cause_e;

    // Address of the opcode-exception vector byte; overflow and div0 follow it.
    localparam int unsigned VEC_BASE_DEFAULT = 253;

    // Vector byte address for a cause: opcode at base, overflow base+1, div0 base+2.
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input cause_e c);
        return base + {30'd0, c} - 32'd1;
    endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority encoder of the three exception flags into a cause code.
// Opcode beats overflow beats divide-by-zero; no flag gives CAUSE_NONE.
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic   flag_opcode_i,
    input  logic   flag_ovf_i,
    input  logic   flag_div0_i,
    output cause_e cause_o
);

    // Highest-priority asserted flag wins; lower ones are simply dropped.
    always_comb begin
        cause_o = CAUSE_NONE;
        if (flag_opcode_i) begin
            cause_o = CAUSE_OPC;
        end else if (flag_ovf_i) begin
            cause_o = CAUSE_OVF;
        end else if (flag_div0_i) begin
            cause_o = CAUSE_DIV0;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry sequencer for the multicycle MIPS core: saves PC-4 into EPC,
// reads the handler byte from the vector table and loads it into the PC while
// stalling the main control unit.
// Optional build macro: EXC_COUNT_EN adds exc_count, a saturating count of
// accepted exceptions.
//
// Strobe protocol: epc_wr, mem_rd and pc_wr are single-cycle pulses with their
// data (epc_data, mem_addr, pc_data) valid in the same cycle; there is no ready
// back-pressure. mem_addr stays valid from the mem_rd cycle until the byte is
// captured MEM_LATENCY cycles later. All outputs decode registered state only.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int unsigned VEC_BASE    = VEC_BASE_DEFAULT,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flag_opcode,
    input  logic        flag_ovf,
    input  logic        flag_div0,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_data,
    output logic        epc_wr,
    output logic [31:0] epc_data,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic        pc_wr,
    output logic [31:0] pc_data,
    output logic        stall,
    output logic [1:0]  cause,
    output logic        exc_active,
`ifdef EXC_COUNT_EN
    output logic [7:0]  exc_count,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [2:0]  LAT      = 3'(MEM_LATENCY);
    localparam logic [31:0] VEC_BASE_W = 32'(VEC_BASE);

    state_e      state_q, state_d;
    cause_e      cause_q, cause_d;
    cause_e      enc_cause;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;

    exc_priority_enc u_enc (
        .flag_opcode_i (flag_opcode),
        .flag_ovf_i    (flag_ovf),
        .flag_div0_i   (flag_div0),
        .cause_o       (enc_cause)
    );

    // State and datapath registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            pc_q    <= 32'd0;
            cnt_q   <= 3'd0;
            byte_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    // Next-state logic: flags are only looked at in IDLE, so no nesting.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: begin
                if (enc_cause != CAUSE_NONE) begin
                    cause_d = enc_cause;
                    pc_d    = pc_in;
                    state_d = SAVE;
                end
            end
            SAVE:  state_d = FETCH;
            FETCH: begin
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Counter hits zero on this edge: the byte is valid now.
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    byte_d  = mem_data;
                    state_d = LOAD_PC;
                end
            end
            LOAD_PC: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state; data buses are zero outside their strobe.
    always_comb begin
        epc_wr     = (state_q == SAVE);
        epc_data   = (state_q == SAVE) ? (pc_q - 32'd4) : 32'd0;
        mem_rd     = (state_q == FETCH);
        mem_addr   = (state_q == FETCH || state_q == WAIT) ? vec_addr(VEC_BASE_W, cause_q) : 32'd0;
        pc_wr      = (state_q == LOAD_PC);
        pc_data    = (state_q == LOAD_PC) ? {24'd0, byte_q} : 32'd0;
        stall      = (state_q != IDLE);
        exc_active = (state_q != IDLE);
        cause      = cause_q;
        dbg_state  = state_q;
    end

`ifdef EXC_COUNT_EN
    logic [7:0] exc_count_q;

    // Count accepted exceptions on entry to SAVE, saturating at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_count_q <= 8'd0;
        end else if (state_q == IDLE && enc_cause != CAUSE_NONE && exc_count_q != 8'hFF) begin
            exc_count_q <= exc_count_q + 8'd1;
        end
    end

    assign exc_count = exc_count_q;
`endif

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer. Two instances run side by side on
// shared inputs: unit 0 with MEM_LATENCY=1, unit 1 with MEM_LATENCY=3. Each has
// its own vector-table memory model with the matching read latency.
module tb_exception_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        flag_opcode, flag_ovf, flag_div0;
    logic [31:0] pc_in;
    logic [7:0]  mem_data   [2];
    logic        epc_wr     [2];
    logic [31:0] epc_data   [2];
    logic        mem_rd     [2];
    logic [31:0] mem_addr   [2];
    logic        pc_wr      [2];
    logic [31:0] pc_data    [2];
    logic        stall      [2];
    logic [1:0]  cause      [2];
    logic        exc_active [2];
    logic [2:0]  dbg_state  [2];
`ifdef EXC_COUNT_EN
    logic [7:0]  exc_count  [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    exception_sequencer #(.VEC_BASE(253), .MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .flag_opcode(flag_opcode), .flag_ovf(flag_ovf), .flag_div0(flag_div0),
        .pc_in(pc_in), .mem_data(mem_data[0]),
        .epc_wr(epc_wr[0]), .epc_data(epc_data[0]),
        .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
        .pc_wr(pc_wr[0]), .pc_data(pc_data[0]),
        .stall(stall[0]), .cause(cause[0]), .exc_active(exc_active[0]),
`ifdef EXC_COUNT_EN
        .exc_count(exc_count[0]),
`endif
        .dbg_state(dbg_state[0])
    );

    exception_sequencer #(.VEC_BASE(253), .MEM_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .flag_opcode(flag_opcode), .flag_ovf(flag_ovf), .flag_div0(flag_div0),
        .pc_in(pc_in), .mem_data(mem_data[1]),
        .epc_wr(epc_wr[1]), .epc_data(epc_data[1]),
        .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
        .pc_wr(pc_wr[1]), .pc_data(pc_data[1]),
        .stall(stall[1]), .cause(cause[1]), .exc_active(exc_active[1]),
`ifdef EXC_COUNT_EN
        .exc_count(exc_count[1]),
`endif
        .dbg_state(dbg_state[1])
    );

    // ---------------- memory model ----------------
    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'd253: return 8'h10;
            32'd254: return 8'h8C;
            32'd255: return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    int          rd_age  [2] = '{-1, -1};
    logic [31:0] rd_addr [2];

    // Byte is presented only in the cycle exactly MEM_LATENCY after mem_rd.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mem_rd[u]) begin
                rd_age[u]  = 0;
                rd_addr[u] = mem_addr[u];
            end else if (rd_age[u] >= 0 && rd_age[u] < 1000) begin
                rd_age[u] = rd_age[u] + 1;
            end
            mem_data[u] = (rd_age[u] == lat_of(u)) ? rom(rd_addr[u]) : 8'hEE;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int u = 0; u < 2; u++) begin
            check_val($sformatf("%s u%0d epc_wr", tag, u), epc_wr[u], 0);
            check_val($sformatf("%s u%0d epc_data", tag, u), epc_data[u], 0);
            check_val($sformatf("%s u%0d mem_rd", tag, u), mem_rd[u], 0);
            check_val($sformatf("%s u%0d mem_addr", tag, u), mem_addr[u], 0);
            check_val($sformatf("%s u%0d pc_wr", tag, u), pc_wr[u], 0);
            check_val($sformatf("%s u%0d pc_data", tag, u), pc_data[u], 0);
            check_val($sformatf("%s u%0d stall", tag, u), stall[u], 0);
            check_val($sformatf("%s u%0d exc_active", tag, u), exc_active[u], 0);
            check_val($sformatf("%s u%0d cause", tag, u), cause[u], 0);
            check_val($sformatf("%s u%0d state", tag, u), dbg_state[u], 0);
        end
    endtask

    // Called at the negedge before the flag-sampling edge; walks the whole
    // sequence plus three idle cycles, checking every output mid-cycle.
    task automatic check_seq(input string tag, input int u, input logic [1:0] c,
                             input logic [31:0] epc, input logic [31:0] addr,
                             input logic [7:0] hbyte);
        int lat;
        lat = lat_of(u);
        @(posedge clk);
        for (int k = 1; k <= 6 + lat; k++) begin
            @(negedge clk);
            if (k <= 3 + lat) begin
                check_val($sformatf("%s u%0d c%0d stall", tag, u, k), stall[u], 1);
                check_val($sformatf("%s u%0d c%0d exc_active", tag, u, k), exc_active[u], 1);
                check_val($sformatf("%s u%0d c%0d cause", tag, u, k), cause[u], c);
                check_val($sformatf("%s u%0d c%0d epc_wr", tag, u, k), epc_wr[u], k == 1);
                check_val($sformatf("%s u%0d c%0d mem_rd", tag, u, k), mem_rd[u], k == 2);
                check_val($sformatf("%s u%0d c%0d pc_wr", tag, u, k), pc_wr[u], k == 3 + lat);
                if (k == 1)
                    check_val($sformatf("%s u%0d epc_data", tag, u), epc_data[u], epc);
                if (k >= 2 && k <= 2 + lat)
                    check_val($sformatf("%s u%0d c%0d mem_addr", tag, u, k), mem_addr[u], addr);
                if (k == 3 + lat)
                    check_val($sformatf("%s u%0d pc_data", tag, u), pc_data[u], {24'd0, hbyte});
            end else begin
                check_val($sformatf("%s u%0d c%0d idle stall", tag, u, k), stall[u], 0);
                check_val($sformatf("%s u%0d c%0d idle exc_active", tag, u, k), exc_active[u], 0);
                check_val($sformatf("%s u%0d c%0d idle epc_wr", tag, u, k), epc_wr[u], 0);
                check_val($sformatf("%s u%0d c%0d idle mem_rd", tag, u, k), mem_rd[u], 0);
                check_val($sformatf("%s u%0d c%0d idle pc_wr", tag, u, k), pc_wr[u], 0);
                check_val($sformatf("%s u%0d c%0d idle cause", tag, u, k), cause[u], c);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_flags(input logic opc, input logic ovf, input logic dv0, input logic [31:0] pc);
        flag_opcode = opc;
        flag_ovf    = ovf;
        flag_div0   = dv0;
        pc_in       = pc;
    endtask

    task automatic pulse_clear;
        @(posedge clk);
        #1;
        flag_opcode = 1'b0;
        flag_ovf    = 1'b0;
        flag_div0   = 1'b0;
    endtask

    // Drives one exception and checks it on both units.
    task automatic run_exc(input string tag, input logic opc, input logic ovf, input logic dv0,
                           input logic [31:0] pc, input logic [1:0] c, input logic [31:0] epc,
                           input logic [31:0] addr, input logic [7:0] hbyte);
        @(negedge clk);
        set_flags(opc, ovf, dv0, pc);
        fork
            pulse_clear();
            check_seq(tag, 0, c, epc, addr, hbyte);
            check_seq(tag, 1, c, epc, addr, hbyte);
        join
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit exceeded");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Overflow pulse: EPC = 0x40-4, vector byte at 254.
        run_exc("ovf", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 2'd2, 32'h0000_003C, 32'd254, 8'h8C);

        // All three flags together: opcode wins, others discarded.
        run_exc("all", 1'b1, 1'b1, 1'b1, 32'h0000_1000, 2'd1, 32'h0000_0FFC, 32'd253, 8'h10);

        // Divide by zero at PC 0: EPC wraps to 0xFFFFFFFC.
        run_exc("div0", 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2'd3, 32'hFFFF_FFFC, 32'd255, 8'hA5);

        // Overflow accepted, then a div0 pulse during WAIT is ignored.
        @(negedge clk);
        set_flags(1'b0, 1'b1, 1'b0, 32'h0000_0200);
        fork
            begin
                pulse_clear();
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                flag_div0 = 1'b1;
                pulse_clear();
            end
            check_seq("nest", 0, 2'd2, 32'h0000_01FC, 32'd254, 8'h8C);
            check_seq("nest", 1, 2'd2, 32'h0000_01FC, 32'd254, 8'h8C);
        join

        // Reset during WAIT aborts at once, and no pc_wr follows release.
        @(negedge clk);
        set_flags(1'b1, 1'b0, 1'b0, 32'h0000_0080);
        pulse_clear();
        @(posedge clk);
        @(posedge clk);
        #2;
        check_val("abort u0 in wait", dbg_state[0], 3);
        check_val("abort u1 in wait", dbg_state[1], 3);
        reset = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                check_val($sformatf("post-abort u%0d c%0d pc_wr", u, k), pc_wr[u], 0);
                check_val($sformatf("post-abort u%0d c%0d epc_wr", u, k), epc_wr[u], 0);
                check_val($sformatf("post-abort u%0d c%0d stall", u, k), stall[u], 0);
            end
        end

`ifdef EXC_COUNT_EN
        // 300 overflow exceptions saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            set_flags(1'b0, 1'b1, 1'b0, 32'h0000_0100);
            pulse_clear();
            repeat (8) @(posedge clk);
            if (i == 0) begin
                check_val("count first u0", exc_count[0], 1);
                check_val("count first u1", exc_count[1], 1);
            end
        end
        @(negedge clk);
        check_val("count sat u0", exc_count[0], 255);
        check_val("count sat u1", exc_count[1], 255);
        reset = 1'b0;
        #1;
        check_val("count reset u0", exc_count[0], 0);
        check_val("count reset u1", exc_count[1], 0);
        @(negedge clk);
        reset = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
